alarm_pio_bank: RTL and testbench

Parametrised Avalon-MM alarm register bank for the alarm-clock SoC. It holds CHANNELS alarm compare values of WIDTH bits each, compares every armed channel against a free-running time input, and latches rising-edge matches into a sticky capture register. A maskable interrupt is raised from the captured matches. It replaces the fixed single 14-bit hours output port with a multi-alarm, interrupt-capable peripheral on the same Nios II Avalon bus.

---
 rtl/alarm_pio_pkg.sv | 16 +
 rtl/alarm_match_channel.sv | 40 ++++
 rtl/alarm_pio_bank.sv | 98 +++++++++
 tb/tb_alarm_pio_bank.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/alarm_pio_pkg.sv
// Shared register map and parameter limits for the alarm PIO bank.
package alarm_pio_pkg;
  localparam logic [3:0] ADDR_ALARM_BASE = 4'd0;
  localparam logic [3:0] ADDR_ENABLE     = 4'd8;
  localparam logic [3:0] ADDR_CAPTURE    = 4'd9;
  localparam logic [3:0] ADDR_IRQ_MASK   = 4'd10;
  localparam logic [3:0] ADDR_STATUS     = 4'd11;

  localparam int MAX_WIDTH    = 32;
  localparam int MAX_CHANNELS = 8;

  function automatic bit params_ok(input int width, input int channels);
    return (width >= 1) && (width <= MAX_WIDTH) &&
           (channels >= 1) && (channels <= MAX_CHANNELS);
  endfunction
endpackage

// File: rtl/alarm_match_channel.sv
// One alarm channel: stored compare value, armed comparator and rising-edge detect.
module alarm_match_channel #(
  parameter int WIDTH = 14
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_dat,
  input  logic [WIDTH-1:0] now_time,
  input  logic             enable,
  output logic [WIDTH-1:0] alarm,
  output logic             match,
  output logic             rise
);
  logic [WIDTH-1:0] alarm_q, alarm_d;
  logic             match_q, match_d;

  always_comb begin
    alarm_d = alarm_q;
    if (wr_en) alarm_d = wr_dat;
  end

  always_comb begin
    match   = enable && (now_time == alarm_q);
    match_d = match;
    rise    = match && !match_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      alarm_q <= '0;
      match_q <= 1'b0;
    end else begin
      alarm_q <= alarm_d;
      match_q <= match_d;
    end
  end

  assign alarm = alarm_q;
endmodule

// File: rtl/alarm_pio_bank.sv
// Avalon-MM alarm bank: per-channel compare values, sticky W1C capture, maskable irq.
// Read data is registered (latency 1); the slave never stalls.
module alarm_pio_bank
  import alarm_pio_pkg::*;
#(
  parameter int WIDTH    = 14,
  parameter int CHANNELS = 4
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [3:0]                address,
  input  logic                      chipselect,
  input  logic                      write_n,
  input  logic                      read_n,
  input  logic [31:0]               writedata,
  output logic [31:0]               readdata,
  input  logic [WIDTH-1:0]          now_time,
  output logic [CHANNELS*WIDTH-1:0] out_port,
  output logic                      irq
);
  if (!params_ok(WIDTH, CHANNELS)) begin : g_param_err
    $error("alarm_pio_bank: WIDTH must be 1..32 and CHANNELS 1..8");
  end

  logic                wr_hit, rd_hit;
  logic [CHANNELS-1:0] enable_q, enable_d;
  logic [CHANNELS-1:0] capture_q, capture_d;
  logic [CHANNELS-1:0] irq_mask_q, irq_mask_d;
  logic [31:0]         readdata_q, readdata_d;
  logic [CHANNELS-1:0] match_vec, rise_vec, w1c;
  logic [WIDTH-1:0]    alarm_val [CHANNELS];
  logic [31:0]         rd_dat;
  logic                unused_wdat;

  assign wr_hit      = chipselect && !write_n;
  assign rd_hit      = chipselect && !read_n;
  assign unused_wdat = ^writedata;

  for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_ch
    alarm_match_channel #(.WIDTH(WIDTH)) u_chan (
      .clk      (clk),
      .reset_n  (reset_n),
      .wr_en    (wr_hit && (address == ADDR_ALARM_BASE + 4'(ch))),
      .wr_dat   (writedata[WIDTH-1:0]),
      .now_time (now_time),
      .enable   (enable_q[ch]),
      .alarm    (alarm_val[ch]),
      .match    (match_vec[ch]),
      .rise     (rise_vec[ch])
    );
    assign out_port[ch*WIDTH +: WIDTH] = alarm_val[ch];
  end

  // A new rising edge beats a simultaneous write-1-to-clear of the same bit.
  always_comb begin
    enable_d   = enable_q;
    irq_mask_d = irq_mask_q;
    w1c        = '0;
    if (wr_hit) begin
      if (address == ADDR_ENABLE)   enable_d   = writedata[CHANNELS-1:0];
      if (address == ADDR_IRQ_MASK) irq_mask_d = writedata[CHANNELS-1:0];
      if (address == ADDR_CAPTURE)  w1c        = writedata[CHANNELS-1:0];
    end
    capture_d = (capture_q & ~w1c) | rise_vec;
  end

  always_comb begin
    rd_dat = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (address == ADDR_ALARM_BASE + 4'(i)) rd_dat = 32'(alarm_val[i]);
    end
    case (address)
      ADDR_ENABLE:   rd_dat = 32'(enable_q);
      ADDR_CAPTURE:  rd_dat = 32'(capture_q);
      ADDR_IRQ_MASK: rd_dat = 32'(irq_mask_q);
      ADDR_STATUS:   rd_dat = 32'(match_vec);
      default:       ;
    endcase
    readdata_d = rd_hit ? rd_dat : readdata_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      enable_q   <= '0;
      capture_q  <= '0;
      irq_mask_q <= '0;
      readdata_q <= '0;
    end else begin
      enable_q   <= enable_d;
      capture_q  <= capture_d;
      irq_mask_q <= irq_mask_d;
      readdata_q <= readdata_d;
    end
  end

  assign readdata = readdata_q;
  assign irq      = |(capture_q & irq_mask_q);
endmodule

// File: tb/tb_alarm_pio_bank.sv
// Self-checking bench for alarm_pio_bank: read responses are scoreboarded, irq/out_port checked inline.
module tb_alarm_pio_bank;
  localparam int WIDTH    = 14;
  localparam int CHANNELS = 4;

  logic                      clk = 1'b0;
  logic                      reset_n;
  logic [3:0]                address;
  logic                      chipselect;
  logic                      write_n;
  logic                      read_n;
  logic [31:0]               writedata;
  logic [31:0]               readdata;
  logic [WIDTH-1:0]          now_time;
  logic [CHANNELS*WIDTH-1:0] out_port;
  logic                      irq;

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [31:0] exp_q [$];
  string       name_q [$];
  logic        rsp_pending = 1'b0;

  alarm_pio_bank #(.WIDTH(WIDTH), .CHANNELS(CHANNELS)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .read_n     (read_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .now_time   (now_time),
    .out_port   (out_port),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  // Scoreboard: a read strobe seen at an edge means readdata must hold the popped value.
  always @(posedge clk) rsp_pending <= reset_n && chipselect && !read_n;

  always @(negedge clk) begin
    if (rsp_pending) begin
      total_cnt++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_read_rsp: readdata=0x%08h with no expected entry", readdata);
      end else begin
        automatic logic [31:0] e = exp_q.pop_front();
        automatic string       n = name_q.pop_front();
        if (readdata !== e)
          $display("FAIL %s: readdata=0x%08h expected=0x%08h", n, readdata, e);
        else
          pass_cnt++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    step();
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic bus_read(input logic [3:0] a, input logic [31:0] e, input string n);
    address = a; chipselect = 1'b1; read_n = 1'b0;
    exp_q.push_back(e);
    name_q.push_back(n);
    step();
    chipselect = 1'b0; read_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; chipselect = 1'b0; write_n = 1'b1; read_n = 1'b1;
    address = '0; writedata = '0; now_time = 14'h3000;
    repeat (2) @(posedge clk);
    #1;
    total_cnt++;
    if (readdata !== 32'h0) $display("FAIL reset_readdata: got 0x%08h expected 0x00000000", readdata);
    else pass_cnt++;
    total_cnt++;
    if (out_port !== '0) $display("FAIL reset_out_port: got 0x%014h expected 0", out_port);
    else pass_cnt++;
    total_cnt++;
    if (irq !== 1'b0) $display("FAIL reset_irq: got %b expected 0", irq);
    else pass_cnt++;
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_reset_mid();
    bus_write(4'd1, 32'h0000_0123);
    bus_write(4'd8, 32'h0000_000F);
    bus_write(4'd10, 32'h0000_000F);
    now_time = 14'h0123;
    step();
    total_cnt++;
    if (irq !== 1'b1) $display("FAIL mid_irq_before_reset: got %b expected 1", irq);
    else pass_cnt++;
    #2 reset_n = 1'b0;
    #1;
    total_cnt++;
    if (out_port !== '0) $display("FAIL mid_reset_out_port: got 0x%014h expected 0", out_port);
    else pass_cnt++;
    total_cnt++;
    if (irq !== 1'b0) $display("FAIL mid_reset_irq: got %b expected 0", irq);
    else pass_cnt++;
    step();
    reset_n = 1'b1;
    now_time = 14'h0000;
    step();
    bus_read(4'd8, 32'h0, "mid_reset_enable");
  endtask

  task automatic test_basic_alarm();
    bus_write(4'd2, 32'h0000_0A3B);
    bus_write(4'd8, 32'h0000_0004);
    bus_write(4'd10, 32'h0000_0004);
    total_cnt++;
    if (out_port[2*WIDTH +: WIDTH] !== 14'h0A3B)
      $display("FAIL basic_out_port_ch2: got 0x%04h expected 0x0a3b", out_port[2*WIDTH +: WIDTH]);
    else pass_cnt++;
    now_time = 14'h0A3A;
    step();
    now_time = 14'h0A3B;
    #1;
    total_cnt++;
    if (irq !== 1'b0) $display("FAIL basic_irq_match_cycle: got %b expected 0", irq);
    else pass_cnt++;
    step();
    total_cnt++;
    if (irq !== 1'b1) $display("FAIL basic_irq_next_cycle: got %b expected 1", irq);
    else pass_cnt++;
    bus_read(4'd9, 32'h4, "basic_capture");
    bus_read(4'd11, 32'h4, "basic_status");
  endtask

  task automatic test_held_match();
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin
        address = 4'd9; writedata = 32'h4; chipselect = 1'b1; write_n = 1'b0;
      end
      step();
      chipselect = 1'b0; write_n = 1'b1;
      total_cnt++;
      if (irq !== (i < 3))
        $display("FAIL held_irq_cycle%0d: got %b expected %b", i, irq, (i < 3));
      else pass_cnt++;
    end
    bus_read(4'd9, 32'h0, "held_capture_cleared");
  endtask

  task automatic test_set_clear();
    bus_write(4'd0, 32'h0000_0100);
    bus_write(4'd8, 32'h0000_0001);
    bus_write(4'd10, 32'h0000_0001);
    now_time = 14'h0100;
    bus_read(4'd9, 32'h0, "setclr_read_in_set_cycle");
    total_cnt++;
    if (irq !== 1'b1) $display("FAIL setclr_first_capture_irq: got %b expected 1", irq);
    else pass_cnt++;
    now_time = 14'h00FF;
    step();
    now_time = 14'h0100;
    bus_write(4'd9, 32'h0000_0001);
    total_cnt++;
    if (irq !== 1'b1) $display("FAIL setclr_irq_after_w1c: got %b expected 1", irq);
    else pass_cnt++;
    bus_read(4'd9, 32'h1, "setclr_capture_set_wins");
  endtask

  task automatic test_mask_trunc();
    bus_write(4'd10, 32'h0);
    bus_write(4'd9, 32'h0000_000F);
    bus_write(4'd0, 32'hFFFF_FFFF);
    bus_read(4'd0, 32'h0000_3FFF, "trunc_alarm0");
    total_cnt++;
    if (out_port[WIDTH-1:0] !== 14'h3FFF)
      $display("FAIL trunc_out_port_ch0: got 0x%04h expected 0x3fff", out_port[WIDTH-1:0]);
    else pass_cnt++;
    now_time = 14'h3FFF;
    step();
    total_cnt++;
    if (irq !== 1'b0) $display("FAIL mask_irq_masked: got %b expected 0", irq);
    else pass_cnt++;
    bus_read(4'd9, 32'h1, "mask_capture");
    bus_read(4'd11, 32'h1, "mask_status");
  endtask

  task automatic test_unmapped();
    logic [CHANNELS*WIDTH-1:0] exp_port;
    exp_port = {14'h0000, 14'h0A3B, 14'h0000, 14'h3FFF};
    bus_write(4'd13, 32'hFFFF_FFFF);
    total_cnt++;
    if (out_port !== exp_port)
      $display("FAIL unmapped_out_port: got 0x%014h expected 0x%014h", out_port, exp_port);
    else pass_cnt++;
    bus_read(4'd13, 32'h0, "unmapped_read13");
    bus_read(4'd5, 32'h0, "unmapped_read5");
    bus_read(4'd10, 32'h0, "unmapped_mask_kept");
    bus_read(4'd8, 32'h1, "unmapped_enable_kept");
    step();
    total_cnt++;
    if (readdata !== 32'h1) $display("FAIL readdata_hold: got 0x%08h expected 0x00000001", readdata);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_reset_mid();
    test_basic_alarm();
    test_held_match();
    test_set_clear();
    test_mask_trunc();
    test_unmapped();
    repeat (2) step();
    total_cnt++;
    if (exp_q.size() != 0) $display("FAIL scoreboard_drain: %0d entries left expected 0", exp_q.size());
    else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end
endmodule
